// File: rtl/persiana_ctrl_multi.sv
// persiana_ctrl_multi: NCH independent blind controllers sharing one prescaler
// and one 2-bit light sensor. Each channel has a motion FSM with travel timeout,
// reversal dead-time, and a latched fault for inconsistent limit switches.
// Optional feature macro: PERSIANA_AUTO_EN enables cmd 100 (follow light level).
module persiana_ctrl_multi #(
    parameter int NCH        = 2,
    parameter int PRESC_W    = 20,
    parameter int TRAVEL_MAX = 40,
    parameter int DEADTIME   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3*NCH-1:0]   cmd,
    input  logic [1:0]         sensor,
    input  logic [NCH-1:0]     ssup,
    input  logic [NCH-1:0]     smed,
    input  logic [NCH-1:0]     sinf,
    output logic [NCH-1:0]     subir,
    output logic [NCH-1:0]     bajar,
    output logic [NCH-1:0]     falla,
    output logic               tick
);

    typedef enum logic [1:0] {P_UNK = 2'd0, P_BOT = 2'd1, P_MID = 2'd2, P_TOP = 2'd3} pos_t;
    typedef enum logic [1:0] {T_NONE = 2'd0, T_BOT = 2'd1, T_MID = 2'd2, T_TOP = 2'd3} tgt_t;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SUBE  = 3'd1,
        S_BAJA  = 3'd2,
        S_PAUSA = 3'd3,
        S_FALLA = 3'd4
    } state_t;

    localparam int TRAV_W = $clog2(TRAVEL_MAX + 1);
    localparam int DEAD_W = $clog2(DEADTIME + 1);
    localparam logic [TRAV_W-1:0]  TRAV_LAST = TRAV_W'(TRAVEL_MAX - 1);
    localparam logic [TRAV_W-1:0]  TRAV_ONE  = TRAV_W'(1);
    localparam logic [DEAD_W-1:0]  DEAD_INIT = DEAD_W'(DEADTIME);
    localparam logic [DEAD_W-1:0]  DEAD_ONE  = DEAD_W'(1);
    localparam logic [PRESC_W-1:0] PRE_ONE   = {{(PRESC_W-1){1'b0}}, 1'b1};
    localparam logic [PRESC_W-1:0] PRE_LAST  = {PRESC_W{1'b1}} - PRE_ONE;

    // Direction needed to reach target t from position p: {up, down}.
    // An unknown position counts as TOP for BOT/MID targets and as BOT for TOP.
    function automatic logic [1:0] dir_of(input tgt_t t, input pos_t p);
        logic [1:0] d;
        case (t)
            T_TOP:   d = (p == P_TOP) ? 2'b00 : 2'b10;
            T_MID: begin
                case (p)
                    P_BOT:   d = 2'b10;
                    P_MID:   d = 2'b00;
                    default: d = 2'b01;
                endcase
            end
            T_BOT:   d = (p == P_BOT) ? 2'b00 : 2'b01;
            default: d = 2'b00;
        endcase
        return d;
    endfunction

`ifdef PERSIANA_AUTO_EN
    // Light level to target; "hold" keeps whatever target was latched before
    function automatic tgt_t light_tgt(input logic [1:0] lvl, input tgt_t prev);
        tgt_t t;
        case (lvl)
            2'b00:   t = T_BOT;
            2'b01:   t = T_MID;
            2'b10:   t = T_TOP;
            default: t = prev;
        endcase
        return t;
    endfunction
`else
    logic unused_sensor_s;
    assign unused_sensor_s = ^sensor;
`endif

    logic [PRESC_W-1:0] presc_r;
    logic               tick_r;

    // Free-running prescaler; tick is registered one count early so it is high exactly while the count is all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_r <= {PRESC_W{1'b0}};
            tick_r  <= 1'b0;
        end else begin
            presc_r <= presc_r + PRE_ONE;
            tick_r  <= (presc_r == PRE_LAST);
        end
    end

    assign tick = tick_r;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [2:0]        cmd_ch_s;
        tgt_t              dec_tgt_s;
        tgt_t              tgt_now_s;
        tgt_t              tgt_r;
        pos_t              pos_now_s;
        pos_t              pos_r;
        state_t            st_r;
        state_t            st_nxt_s;
        logic [TRAV_W-1:0] trav_r;
        logic [TRAV_W-1:0] trav_nxt_s;
        logic [DEAD_W-1:0] dead_r;
        logic [DEAD_W-1:0] dead_nxt_s;
        logic [1:0]        dir_s;
        logic              run_cmd_s;
        logic              hit_s;
        logic              both_s;
        logic              subir_r;
        logic              bajar_r;
        logic              falla_r;

        assign cmd_ch_s = cmd[3*i +: 3];
        assign both_s   = ssup[i] & sinf[i];

        // Decode this channel's command into a target; run_cmd_s is low for every stop code
        always_comb begin
            run_cmd_s = 1'b1;
            dec_tgt_s = T_NONE;
            case (cmd_ch_s)
                3'b001:  dec_tgt_s = T_BOT;
                3'b010:  dec_tgt_s = T_MID;
                3'b011:  dec_tgt_s = T_TOP;
`ifdef PERSIANA_AUTO_EN
                3'b100:  dec_tgt_s = light_tgt(sensor, tgt_r);
`endif
                default: begin
                    run_cmd_s = 1'b0;
                    dec_tgt_s = T_NONE;
                end
            endcase
        end

        // The target seen by the FSM is the freshly latched one during a tick cycle
        assign tgt_now_s = tick_r ? dec_tgt_s : tgt_r;

        // Live position: a limit switch overrides the remembered position
        always_comb begin
            if (sinf[i]) begin
                pos_now_s = P_BOT;
            end else if (smed[i]) begin
                pos_now_s = P_MID;
            end else if (ssup[i]) begin
                pos_now_s = P_TOP;
            end else begin
                pos_now_s = pos_r;
            end
        end

        // Target-sensor hit for the current target
        always_comb begin
            case (tgt_now_s)
                T_TOP:   hit_s = ssup[i];
                T_MID:   hit_s = smed[i];
                T_BOT:   hit_s = sinf[i];
                default: hit_s = 1'b0;
            endcase
        end

        assign dir_s = dir_of(tgt_now_s, pos_now_s);

        // Next-state and counter logic; limit stops act every clock, everything else on tick
        always_comb begin
            st_nxt_s   = st_r;
            trav_nxt_s = trav_r;
            dead_nxt_s = dead_r;
            if (both_s) begin
                st_nxt_s = S_FALLA;
            end else begin
                case (st_r)
                    S_IDLE: begin
                        if (tick_r && (dir_s != 2'b00)) begin
                            st_nxt_s   = dir_s[1] ? S_SUBE : S_BAJA;
                            trav_nxt_s = {TRAV_W{1'b0}};
                        end else begin
                            st_nxt_s = S_IDLE;
                        end
                    end
                    S_SUBE, S_BAJA: begin
                        if (hit_s || ((st_r == S_SUBE) ? ssup[i] : sinf[i])) begin
                            st_nxt_s = S_IDLE;
                        end else if (tick_r) begin
                            if (dir_s == 2'b00) begin
                                st_nxt_s = S_IDLE;
                            end else if (dir_s[1] != (st_r == S_SUBE)) begin
                                st_nxt_s   = S_PAUSA;
                                dead_nxt_s = DEAD_INIT;
                            end else if (trav_r == TRAV_LAST) begin
                                st_nxt_s = S_FALLA;
                            end else begin
                                trav_nxt_s = trav_r + TRAV_ONE;
                            end
                        end else begin
                            st_nxt_s = st_r;
                        end
                    end
                    S_PAUSA: begin
                        if (tick_r) begin
                            if (dir_s == 2'b00) begin
                                st_nxt_s   = S_IDLE;
                                dead_nxt_s = {DEAD_W{1'b0}};
                            end else if (dead_r <= DEAD_ONE) begin
                                st_nxt_s   = dir_s[1] ? S_SUBE : S_BAJA;
                                trav_nxt_s = {TRAV_W{1'b0}};
                                dead_nxt_s = {DEAD_W{1'b0}};
                            end else begin
                                dead_nxt_s = dead_r - DEAD_ONE;
                            end
                        end else begin
                            st_nxt_s = S_PAUSA;
                        end
                    end
                    S_FALLA: begin
                        if (tick_r && !run_cmd_s) begin
                            st_nxt_s   = S_IDLE;
                            trav_nxt_s = {TRAV_W{1'b0}};
                            dead_nxt_s = {DEAD_W{1'b0}};
                        end else begin
                            st_nxt_s = S_FALLA;
                        end
                    end
                    default: begin
                        st_nxt_s = S_FALLA;
                    end
                endcase
            end
        end

        // Channel FSM state, latched target/position, counters and registered drives
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                st_r    <= S_IDLE;
                tgt_r   <= T_NONE;
                pos_r   <= P_UNK;
                trav_r  <= {TRAV_W{1'b0}};
                dead_r  <= {DEAD_W{1'b0}};
                subir_r <= 1'b0;
                bajar_r <= 1'b0;
                falla_r <= 1'b0;
            end else begin
                st_r    <= st_nxt_s;
                tgt_r   <= tgt_now_s;
                pos_r   <= pos_now_s;
                trav_r  <= trav_nxt_s;
                dead_r  <= dead_nxt_s;
                subir_r <= (st_nxt_s == S_SUBE);
                bajar_r <= (st_nxt_s == S_BAJA);
                falla_r <= (st_nxt_s == S_FALLA);
            end
        end

        assign subir[i] = subir_r;
        assign bajar[i] = bajar_r;
        assign falla[i] = falla_r;
    end

endmodule

// File: tb/tb_persiana_ctrl_multi.sv
// Directed testbench for persiana_ctrl_multi with NCH=2, PRESC_W=4,
// TRAVEL_MAX=8, DEADTIME=2 (tick every 16 clocks). Build with or without
// PERSIANA_AUTO_EN; the auto-mode expectations follow the macro.
module tb_persiana_ctrl_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] cmd;
    logic [1:0] sensor;
    logic [1:0] ssup, smed, sinf;
    logic [1:0] subir, bajar, falla;
    logic       tick;

    int tests = 0;
    int fails = 0;

    persiana_ctrl_multi #(
        .NCH(2), .PRESC_W(4), .TRAVEL_MAX(8), .DEADTIME(2)
    ) dut (
        .clk(clk), .reset(rst), .cmd(cmd), .sensor(sensor),
        .ssup(ssup), .smed(smed), .sinf(sinf),
        .subir(subir), .bajar(bajar), .falla(falla), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1; cmd = 6'd0; sensor = 2'b00;
        ssup = 2'b00; smed = 2'b00; sinf = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns at a negedge inside a tick cycle; inputs set now are latched at the next edge
    task automatic wait_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (tick !== 1'b1) begin
            tests++; fails++;
            $display("FAIL wait_tick: tick=%b after %0d clocks, required 1", tick, n);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        do_reset();
        tests++; if (subir !== 2'b00) begin fails++; $display("FAIL reset_subir: got %b required 00", subir); end
        tests++; if (bajar !== 2'b00) begin fails++; $display("FAIL reset_bajar: got %b required 00", bajar); end
        tests++; if (falla !== 2'b00) begin fails++; $display("FAIL reset_falla: got %b required 00", falla); end
        tests++; if (tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b required 0", tick); end
        while (tick !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        tests++; if (n != 15) begin fails++; $display("FAIL first_tick: got %0d clocks required 15", n); end
        @(negedge clk);
        tests++; if (tick !== 1'b0) begin fails++; $display("FAIL tick_pulse: got %b required 0", tick); end
        n = 1;
        while (tick !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        tests++; if (n != 16) begin fails++; $display("FAIL tick_period: got %0d required 16", n); end
    endtask

    task automatic test_open();
        int n = 0;
        do_reset();
        cmd = 6'b000_011;
        while (subir !== 2'b01 && n < 40) begin @(negedge clk); n++; end
        tests++; if (n > 16) begin fails++; $display("FAIL open_latency: got %0d clocks required <=16", n); end
        tests++; if (subir !== 2'b01 || bajar !== 2'b00) begin fails++; $display("FAIL open_drive: got subir=%b bajar=%b required 01/00", subir, bajar); end
        ssup = 2'b01;
        @(negedge clk);
        tests++; if (subir !== 2'b00) begin fails++; $display("FAIL open_limit: got subir=%b required 00", subir); end
        ssup = 2'b00;
        wait_tick();
        @(negedge clk);
        tests++; if (subir !== 2'b00 || bajar !== 2'b00) begin fails++; $display("FAIL open_hold_top: got subir=%b bajar=%b required 00/00", subir, bajar); end
    endtask

    task automatic test_mid();
        cmd = 6'b000_010;
        wait_tick();
        @(negedge clk);
        tests++; if (bajar !== 2'b01 || subir !== 2'b00) begin fails++; $display("FAIL mid_drive: got subir=%b bajar=%b required 00/01", subir, bajar); end
        repeat (3) @(negedge clk);
        smed = 2'b01;
        @(negedge clk);
        tests++; if (bajar !== 2'b00) begin fails++; $display("FAIL mid_limit: got bajar=%b required 00", bajar); end
        smed = 2'b00;
        tests++; if ({subir[1], bajar[1], falla[1]} !== 3'b000) begin fails++; $display("FAIL mid_ch1_quiet: got %b required 000", {subir[1], bajar[1], falla[1]}); end
    endtask

    task automatic test_reversal();
        int low = 0;
        cmd = 6'b000_011;
        wait_tick();
        @(negedge clk);
        tests++; if (subir !== 2'b01) begin fails++; $display("FAIL rev_up: got subir=%b required 01", subir); end
        cmd = 6'b000_001;
        wait_tick();
        @(negedge clk);
        while (subir === 2'b00 && bajar === 2'b00 && low < 100) begin low++; @(negedge clk); end
        tests++; if (low != 32) begin fails++; $display("FAIL rev_deadtime: got %0d low clocks required 32", low); end
        tests++; if (bajar !== 2'b01 || subir !== 2'b00) begin fails++; $display("FAIL rev_down: got subir=%b bajar=%b required 00/01", subir, bajar); end
        sinf = 2'b01;
        @(negedge clk);
        tests++; if (bajar !== 2'b00) begin fails++; $display("FAIL rev_bottom: got bajar=%b required 00", bajar); end
        sinf = 2'b00;
    endtask

    task automatic test_timeout();
        int hi = 0;
        do_reset();
        cmd = 6'b000_001;
        wait_tick();
        @(negedge clk);
        while (bajar === 2'b01 && hi < 300) begin hi++; @(negedge clk); end
        tests++; if (hi != 128) begin fails++; $display("FAIL timeout_len: got %0d clocks required 128", hi); end
        tests++; if (falla !== 2'b01) begin fails++; $display("FAIL timeout_falla: got %b required 01", falla); end
        tests++; if (subir !== 2'b00 || bajar !== 2'b00) begin fails++; $display("FAIL timeout_drives: got subir=%b bajar=%b required 00/00", subir, bajar); end
        cmd = 6'b000_011;
        wait_tick();
        @(negedge clk);
        tests++; if (falla !== 2'b01 || subir !== 2'b00) begin fails++; $display("FAIL fault_sticky: got falla=%b subir=%b required 01/00", falla, subir); end
        cmd = 6'b000_000;
        wait_tick();
        @(negedge clk);
        tests++; if (falla !== 2'b00) begin fails++; $display("FAIL fault_clear: got falla=%b required 00", falla); end
    endtask

    task automatic test_limit_fault();
        do_reset();
        cmd = 6'b000_011;
        wait_tick();
        @(negedge clk);
        ssup = 2'b10; sinf = 2'b10;
        @(negedge clk);
        tests++; if (falla !== 2'b10) begin fails++; $display("FAIL both_limits: got falla=%b required 10", falla); end
        tests++; if (subir !== 2'b01) begin fails++; $display("FAIL both_ch0_unaffected: got subir=%b required 01", subir); end
        ssup = 2'b00; sinf = 2'b00;
        wait_tick();
        @(negedge clk);
        tests++; if (falla !== 2'b00 || subir !== 2'b01) begin fails++; $display("FAIL both_clear: got falla=%b subir=%b required 00/01", falla, subir); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cmd = {3'b001, 3'b011};
        wait_tick();
        @(negedge clk);
        tests++; if (subir !== 2'b01 || bajar !== 2'b10) begin fails++; $display("FAIL dual_motion: got subir=%b bajar=%b required 01/10", subir, bajar); end
        ssup = 2'b01;
        @(negedge clk);
        ssup = 2'b00;
        tests++; if (subir !== 2'b00 || bajar !== 2'b10) begin fails++; $display("FAIL dual_indep: got subir=%b bajar=%b required 00/10", subir, bajar); end
    endtask

    task automatic test_async_reset();
        #2 rst = 1'b1;
        #1;
        tests++; if (bajar !== 2'b00 || subir !== 2'b00 || falla !== 2'b00) begin fails++; $display("FAIL async_reset: got subir=%b bajar=%b falla=%b required 00/00/00", subir, bajar, falla); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_auto();
        int low = 0;
        do_reset();
        cmd = 6'b000_100;
        sensor = 2'b10;
        wait_tick();
        @(negedge clk);
`ifdef PERSIANA_AUTO_EN
        tests++; if (subir !== 2'b01) begin fails++; $display("FAIL auto_bright: got subir=%b required 01", subir); end
        sensor = 2'b00;
        wait_tick();
        @(negedge clk);
        while (subir === 2'b00 && bajar === 2'b00 && low < 100) begin low++; @(negedge clk); end
        tests++; if (low != 32 || bajar !== 2'b01) begin fails++; $display("FAIL auto_reverse: got low=%0d bajar=%b required 32/01", low, bajar); end
        sensor = 2'b11;
        wait_tick();
        @(negedge clk);
        tests++; if (bajar !== 2'b01) begin fails++; $display("FAIL auto_hold: got bajar=%b required 01", bajar); end
`else
        tests++; if (subir !== 2'b00 || bajar !== 2'b00) begin fails++; $display("FAIL auto_off_bright: got subir=%b bajar=%b required 00/00", subir, bajar); end
        sensor = 2'b00;
        wait_tick();
        @(negedge clk);
        while (subir === 2'b00 && bajar === 2'b00 && low < 40) begin low++; @(negedge clk); end
        tests++; if (low != 40) begin fails++; $display("FAIL auto_off_dark: got idle=%0d clocks required 40", low); end
        sensor = 2'b11;
        wait_tick();
        @(negedge clk);
        tests++; if (subir !== 2'b00 || bajar !== 2'b00) begin fails++; $display("FAIL auto_off_hold: got subir=%b bajar=%b required 00/00", subir, bajar); end
`endif
    endtask

    initial begin
        test_reset();
        test_open();
        test_mid();
        test_reversal();
        test_timeout();
        test_limit_fault();
        test_back_to_back();
        test_async_reset();
        test_auto();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
